// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add multiply and restoring divide.
// Build option: define MDU_FAST_MUL_EN to replace the multiply sequence with one 33x33 signed multiply.
module mdu_sequencer #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [31:0]      rs1,
    input  logic [31:0]      rs2,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t            state_r, state_s;
    logic [2:0]        op_r;
    logic [TAG_W-1:0]  tag_r;
    logic [31:0]       a_r, hi_r, lo_r, result_r;
    logic              neg_r, out_valid_r;
    logic [4:0]        cnt_r;

    logic              accept_s, div_zero_s, div_ovf_s, special_s, fast_s, neg_in_s, div_ge_s;
    logic [31:0]       abs1_s, abs2_s, x_s, y_s, q_fix_s, r_fix_s, res_sel_s;
    logic [32:0]       mul_sum_s, div_shift_s;
    logic [63:0]       prod_s, prod_fix_s;

    assign accept_s   = in_valid && (state_r == IDLE) && !flush;
    assign div_zero_s = op[2] && (rs2 == 32'd0);
    assign div_ovf_s  = op[2] && !op[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    assign special_s  = div_zero_s || div_ovf_s;
    assign abs1_s     = rs1[31] ? (32'd0 - rs1) : rs1;
    assign abs2_s     = rs2[31] ? (32'd0 - rs2) : rs2;

`ifdef MDU_FAST_MUL_EN
    logic signed [32:0] fa_s, fb_s;
    logic signed [63:0] fprod_s;
    assign fa_s    = {(op != 3'd3) && rs1[31], rs1};
    assign fb_s    = {(op == 3'd1) && rs2[31], rs2};
    assign fprod_s = 64'(fa_s) * 64'(fb_s);
    assign fast_s  = !op[2];
`else
    assign fast_s  = 1'b0;
`endif

    // Operand magnitudes and result sign chosen by the op's signedness rules
    always_comb begin
        x_s      = rs1;
        y_s      = rs2;
        neg_in_s = 1'b0;
        case (op)
            3'd1, 3'd4: begin x_s = abs1_s; y_s = abs2_s; neg_in_s = rs1[31] ^ rs2[31]; end
            3'd2:       begin x_s = abs1_s; y_s = rs2;    neg_in_s = rs1[31]; end
            3'd6:       begin x_s = abs1_s; y_s = abs2_s; neg_in_s = rs1[31]; end
            default:    begin x_s = rs1;    y_s = rs2;    neg_in_s = 1'b0; end
        endcase
    end

    // One iteration: a_r is the multiplicand or the divisor, lo_r the multiplier or dividend
    assign mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, a_r} : 33'd0);
    assign div_shift_s = {hi_r, lo_r[31]};
    assign div_ge_s    = div_shift_s >= {1'b0, a_r};

    assign prod_s     = {hi_r, lo_r};
    assign prod_fix_s = neg_r ? (64'd0 - prod_s) : prod_s;
    assign q_fix_s    = neg_r ? (32'd0 - lo_r) : lo_r;
    assign r_fix_s    = neg_r ? (32'd0 - hi_r) : hi_r;

    // Result selection by latched op
    always_comb begin
        res_sel_s = 32'd0;
        case (op_r)
            3'd0:             res_sel_s = prod_fix_s[31:0];
            3'd1, 3'd2, 3'd3: res_sel_s = prod_fix_s[63:32];
            3'd4, 3'd5:       res_sel_s = q_fix_s;
            3'd6, 3'd7:       res_sel_s = r_fix_s;
            default:          res_sel_s = 32'd0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // FSM next-state logic; flush overrides every state
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = (special_s || fast_s) ? DONE : CALC;
                else          state_s = IDLE;
            end
            CALC: begin
                if (cnt_r == 5'd31) state_s = DONE;
                else                state_s = CALC;
            end
            DONE: begin
                if (out_valid_r && out_ready) state_s = IDLE;
                else                          state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
        if (flush) state_s = IDLE;
        else       state_s = state_s;
    end

    // Operand capture, iteration datapath, and registered result/out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r        <= 3'd0;
            tag_r       <= '0;
            a_r         <= 32'd0;
            hi_r        <= 32'd0;
            lo_r        <= 32'd0;
            neg_r       <= 1'b0;
            cnt_r       <= 5'd0;
            result_r    <= 32'd0;
            out_valid_r <= 1'b0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r  <= op;
                        tag_r <= tag;
                        cnt_r <= 5'd0;
                        a_r   <= op[2] ? y_s : x_s;
                        if (div_zero_s) begin
                            lo_r <= 32'hFFFF_FFFF; hi_r <= rs1; neg_r <= 1'b0;
                        end else if (div_ovf_s) begin
                            lo_r <= 32'h8000_0000; hi_r <= 32'd0; neg_r <= 1'b0;
`ifdef MDU_FAST_MUL_EN
                        end else if (fast_s) begin
                            {hi_r, lo_r} <= fprod_s; neg_r <= 1'b0;
`endif
                        end else begin
                            lo_r <= op[2] ? x_s : y_s; hi_r <= 32'd0; neg_r <= neg_in_s;
                        end
                    end
                end
                CALC: begin
                    cnt_r <= cnt_r + 5'd1;
                    if (op_r[2]) begin
                        hi_r <= div_ge_s ? 32'(div_shift_s - {1'b0, a_r}) : div_shift_s[31:0];
                        lo_r <= {lo_r[30:0], div_ge_s};
                    end else begin
                        hi_r <= mul_sum_s[32:1];
                        lo_r <= {mul_sum_s[0], lo_r[31:1]};
                    end
                end
                DONE: begin
                    if (!out_valid_r) begin
                        result_r    <= res_sel_s;
                        out_valid_r <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: out_valid_r <= 1'b0;
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign busy      = (state_r != IDLE);
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign out_tag   = tag_r;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed RV32M corner cases plus random ops
// checked against an arithmetic reference model (result, tag, latency, handshake).
module tb_mdu_sequencer;
    localparam int TAG_W = 5;

    logic             clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0]       op;
    logic [31:0]      rs1, rs2, result;
    logic [TAG_W-1:0] tag, out_tag;
    int               n_cmp = 0;
    int               n_err = 0;

    mdu_sequencer #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs1(rs1), .rs2(rs2), .tag(tag), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_tag(out_tag), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // RISC-V M semantics with plain 64-bit arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'(signed'(a));
        sb  = longint'(signed'(b));
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0:    p = 64'(sa * sb);
            3'd1:    p = 64'(sa * sb) >> 32;
            3'd2:    p = 64'(sa * ub) >> 32;
            3'd3:    p = ({32'd0, a} * {32'd0, b}) >> 32;
            3'd4:    p = (b == 32'd0) ? 64'hFFFF_FFFF : ovf ? 64'h8000_0000 : 64'(sa / sb);
            3'd5:    p = (b == 32'd0) ? 64'hFFFF_FFFF : 64'(a / b);
            3'd6:    p = (b == 32'd0) ? {32'd0, a} : ovf ? 64'd0 : 64'(sa % sb);
            default: p = (b == 32'd0) ? {32'd0, a} : 64'(a % b);
        endcase
        return p[31:0];
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f >= 3'd4 && b == 32'd0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MDU_FAST_MUL_EN
        if (f < 3'd4) return 1;
`endif
        return 33;
    endfunction

    // Issue one op, measure latency, hold the result for 'hold' cycles, then take it
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] t, input int hold, input bit overlap);
        logic [31:0] exp;
        int          lat, n;
        exp = ref_result(f, a, b);
        lat = ref_lat(f, a, b);
        chk("in_ready_idle", in_ready, 1);
        op = f; rs1 = a; rs2 = b; tag = t; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 3'($urandom); rs1 = $urandom; rs2 = $urandom; tag = TAG_W'($urandom);
        chk("busy_after_accept", busy, 1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, lat);
        chk("result", result, exp);
        chk("out_tag", out_tag, t);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_result", result, exp);
            chk("hold_tag", out_tag, t);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        if (overlap) in_valid = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        if (overlap) chk("overlap_not_accepted", busy, 0);
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 300));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int seen;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; rs1 = 32'd0; rs2 = 32'd0; tag = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_out_tag", out_tag, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 0, 1'b0);
        chk("mul_7x-3", ref_result(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 0, 1'b0);
        do_op(3'd2, 32'h8000_0000, 32'h8000_0000, 5'd4, 0, 1'b0);
        do_op(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd5, 0, 1'b0);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, 1'b0);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 0, 1'b0);
        do_op(3'd5, 32'd100, 32'd7, 5'd8, 0, 1'b0);
        do_op(3'd7, 32'd100, 32'd7, 5'd9, 0, 1'b0);
        do_op(3'd4, 32'h1234_5678, 32'd0, 5'd10, 0, 1'b0);
        do_op(3'd6, 32'h1234_5678, 32'd0, 5'd11, 0, 1'b0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0, 1'b0);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0, 1'b0);
        do_op(3'd1, 32'hDEAD_BEEF, 32'h1357_9BDF, 5'd14, 10, 1'b1);

        // Flush mid-calculation drops the op; the next op carries its own tag
        op = 3'd5; rs1 = 32'd1000; rs2 = 32'd3; tag = 5'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_in_ready", in_ready, 1);
        chk("flush_busy", busy, 0);
        chk("flush_out_valid", out_valid, 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("flush_no_result", seen, 0);
        do_op(3'd0, 32'd5, 32'd6, 5'd3, 0, 1'b0);

        // Flush together with in_valid in IDLE: not accepted
        op = 3'd0; rs1 = 32'd2; rs2 = 32'd3; tag = 5'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        chk("flush_blocks_accept", busy, 0);
        in_valid = 1'b0; flush = 1'b0;

        // Asynchronous reset during calculation
        op = 3'd4; rs1 = 32'd77; rs2 = 32'd5; tag = 5'd20; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_tag", out_tag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("midrst_no_result", seen, 0);

        for (int k = 0; k < 40; k++) begin
            do_op(3'($urandom), rand_operand(), rand_operand(), TAG_W'($urandom),
                  $urandom_range(0, 3), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
